hcsr04_responder: RTL and testbench
===================================

# hcsr04_responder

Synthesizable responder for the HC-SR04-style ultrasonic ranging protocol, at the sensor end of the radar's trigger/echo link. It qualifies a trigger pulse and waits out the acoustic burst time. It then drives an echo pulse whose width encodes a programmable target distance, so the trigger generator and echo counter can be exercised in simulation and on hardware without a physical sensor. One clock cycle is 1 us.

## Interface
- `TRIG_MIN_CYC`, default 10: minimum trigger high width in cycles (10 us).
- `BURST_CYC`, default 200: delay from trigger fall to echo rise (8 cycles at 40 kHz).
- `CYC_PER_CM`, default 58: echo cycles per centimetre.
- `MIN_CM`, default 2: lowest in-range distance.
- `MAX_CM`, default 400: highest in-range distance.
- `TIMEOUT_CYC`, default 38000: echo width for an out-of-range target.
- `HOLDOFF_CYC`, default 10000: dead time after echo fall.
- `CNT_W`, default 18: width of the timing counter and echo-width register.
- `DIST_W`, default 9: width of the distance input.

Ports:
- `clk`, in, 1: system clock, 1 MHz.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `trig`, in, 1: trigger from the trigger generator; synchronous to `clk`.
- `distance_cm`, in, DIST_W: target distance, sampled once per measurement.
- `echo`, out, 1: echo pulse, registered.
- `busy`, out, 1: a measurement is in progress; triggers are ignored while high.
- `trig_err`, out, 1: one-cycle pulse when a trigger shorter than `TRIG_MIN_CYC` is rejected.

## Operation
- The clock is named `clk`. Reset is synchronous and active-low, named `rst_n`; it is sampled on rising `clk`.
- Outputs while `rst_n`=0, and on the edge after it is asserted: `echo`=0, `busy`=0, `trig_err`=0.
- Internal state under reset: state=IDLE, all counters 0, `trig_q`=1. Setting `trig_q`=1 makes a trigger already high at reset release wait for a fresh rise.
- `trig_q` is a registered copy of `trig`, used for edge detection.
- State machine:
  - IDLE: `trig`=1 and `trig_q`=0 (a rising edge) → TRIG_HI, with cnt=1.
  - TRIG_HI, `trig`=1: cnt increments and saturates at `TRIG_MIN_CYC`.
  - TRIG_HI, `trig`=0 with cnt ≥ `TRIG_MIN_CYC`: → BURST. Latch the echo width W, set `busy`=1, cnt=0.
  - TRIG_HI, `trig`=0 with cnt < `TRIG_MIN_CYC`: → IDLE and pulse `trig_err` for one cycle.
  - BURST: count `BURST_CYC` cycles → ECHO, set `echo`=1.
  - ECHO: count W cycles → HOLDOFF, set `echo`=0.
  - HOLDOFF: count `HOLDOFF_CYC` cycles → IDLE, set `busy`=0.
- Echo width W is computed at trigger fall from `distance_cm`:
  - `distance_cm` × `CYC_PER_CM`, constant multiply, result in CNT_W bits.
  - Out-of-range handling (below `MIN_CM` or above `MAX_CM`) depends on the build; see Configuration.
  - `distance_cm` changes after latching do not affect the current echo.
- `trig` activity in BURST, ECHO or HOLDOFF is ignored and does not raise `trig_err`.
- If `trig` is still high on return to IDLE, it must fall and rise again before it counts.
- Clearing `rst_n` mid-measurement aborts it: `echo` and `busy` are 0 on the next edge, and no partial echo resumes.

## Timing
- Reference edge E0: the first rising edge at which `trig`=0 is sampled after a qualified high phase.
- `busy` is 1 from E0 to E0+BURST_CYC+W+HOLDOFF_CYC.
- `echo` rises at E0+BURST_CYC and falls at E0+BURST_CYC+W; its high time is exactly W cycles.
- `trig_err` is high for the single cycle after E0 when the trigger is rejected.
- Minimum trigger-to-trigger spacing is TRIG_MIN_CYC+1+BURST_CYC+W+HOLDOFF_CYC.

## Configuration
- `HCSR04_TIMEOUT_EN` defined: an out-of-range distance gives W=`TIMEOUT_CYC`, mimicking sensor no-echo behaviour.
- `HCSR04_TIMEOUT_EN` undefined: the distance is clamped to [`MIN_CM`, `MAX_CM`] before the multiply, so the echo is never wider than `MAX_CM`×`CYC_PER_CM`.

## Structure
- Package `radar_pkg` holds:
  - the state enum (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF);
  - default timing constants: 1 us tick, 58 cyc/cm, 38000-cycle timeout, 18-bit counter width.
- The echo counter and trigger generator also use `radar_pkg`.
- Sub-module `trig_qualifier`: rising-edge detect, saturating width counter, and accept/reject strobes. The top level holds the state machine, echo-width computation and the single shared timing counter.

## Test plan
- Trigger high 10 cycles, `distance_cm`=100 → `echo` rises at E0+200, stays high 5800 cycles, `busy` falls at E0+16000, `trig_err` stays 0.
- Trigger high 9 cycles → `trig_err` high for one cycle, `echo` and `busy` stay 0, state returns to IDLE.
- Second trigger during ECHO, then one 5 cycles after `busy` falls, `distance_cm`=2 → first ignored; second gives a 116-cycle echo.
- `distance_cm`=450 → echo width 38000 with `HCSR04_TIMEOUT_EN`; 23200 without.
- `rst_n`=0 for one cycle mid-ECHO → `echo`=0 and `busy`=0 next edge; a trigger high at reset release is ignored until it falls and rises again.
- `distance_cm` changed from 100 to 10 at E0+50 → echo width stays 5800.

Source files
------------

// File: rtl/radar_pkg.sv
// Shared types and default timing constants for the radar trigger/echo blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package radar_pkg;

    // Measurement sequencer states, shared by the responder and the echo counter.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    // One clock cycle is one microsecond.
    localparam int CYC_PER_US      = 1;
    // Round-trip acoustic time per centimetre of target distance.
    localparam int CYC_PER_CM_DEF  = 58 * CYC_PER_US;
    // Echo width a real sensor produces when nothing answers.
    localparam int TIMEOUT_CYC_DEF = 38000 * CYC_PER_US;
    // Wide enough for the timeout width and the largest in-range echo.
    localparam int CNT_W_DEF       = 18;

endpackage

// File: rtl/trig_qualifier.sv
// Trigger qualifier: edge detect plus saturating high-width counter with accept/reject strobes.
// Latency: rise/accept/reject are combinational from trig and registered history (same cycle).
// Backpressure: none; arm/track from the owner decide when trig is looked at.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   trig        : trigger input, synchronous to clk
//   arm         : owner is idle and will accept a new rising edge
//   track       : owner is timing a high phase that started with rise
//   rise        : fresh rising edge seen while armed
//   accept      : trig fell after at least TRIG_MIN_CYC high cycles
//   reject      : trig fell before TRIG_MIN_CYC high cycles
module trig_qualifier #(
    parameter int TRIG_MIN_CYC = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    input  logic arm,
    input  logic track,
    output logic rise,
    output logic accept,
    output logic reject
);

    localparam int                WCNT_W = $clog2(TRIG_MIN_CYC + 1);
    localparam logic [WCNT_W-1:0] WMAX   = WCNT_W'(TRIG_MIN_CYC);

    logic              trig_q;
    logic [WCNT_W-1:0] wcnt;

    assign rise   = arm & trig & ~trig_q;
    assign accept = track & ~trig & (wcnt >= WMAX);
    assign reject = track & ~trig & (wcnt <  WMAX);

    // trig_q resets high so a trigger already asserted at reset release
    // has to drop and rise again before it is seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_q <= 1'b1;
            wcnt   <= '0;
        end else begin
            trig_q <= trig;
            if (rise) begin
                wcnt <= WCNT_W'(1);
            end else if (track && trig && (wcnt < WMAX)) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hcsr04_responder.sv
// HC-SR04 sensor-side model: qualifies a trigger, waits the burst time, returns a distance-coded echo.
// Latency: echo rises BURST_CYC cycles after the trigger fall is sampled; high for exactly W cycles.
// Backpressure: none; triggers arriving while busy are dropped silently.
//
// Ports:
//   clk, rst_n   : 1 MHz clock, synchronous active-low reset
//   trig         : trigger from the trigger generator
//   distance_cm  : target distance, latched when the trigger is accepted
//   echo         : registered echo pulse
//   busy         : measurement in progress (burst, echo and hold-off)
//   trig_err     : one-cycle strobe when a too-short trigger is rejected
//
// Build option: define HCSR04_TIMEOUT_EN to answer out-of-range distances with a
// TIMEOUT_CYC echo; otherwise the distance is clamped to [MIN_CM, MAX_CM].
module hcsr04_responder
    import radar_pkg::*;
#(
    parameter int TRIG_MIN_CYC = 10 * CYC_PER_US,
    parameter int BURST_CYC    = 200,
    parameter int CYC_PER_CM   = CYC_PER_CM_DEF,
    parameter int MIN_CM       = 2,
    parameter int MAX_CM       = 400,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
    parameter int HOLDOFF_CYC  = 10000,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DIST_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] distance_cm,
    output logic              echo,
    output logic              busy,
    output logic              trig_err
);

`ifdef HCSR04_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Terminal counts: the shared counter runs 0..N-1 in each timed state.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_D      = CNT_W'(MIN_CM);
    localparam logic [CNT_W-1:0] MAX_D      = CNT_W'(MAX_CM);
    localparam logic [CNT_W-1:0] MULT       = CNT_W'(CYC_PER_CM);
    localparam logic [CNT_W-1:0] TMO_W      = CNT_W'(TIMEOUT_CYC);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] echo_last;   // echo width minus one, latched at trigger fall

    logic             rise;
    logic             accept;
    logic             reject;

    logic [CNT_W-1:0] dist_ext;
    logic [CNT_W-1:0] dist_c;
    logic [CNT_W-1:0] width_nxt;
    logic             below;
    logic             above;

    trig_qualifier #(
        .TRIG_MIN_CYC (TRIG_MIN_CYC)
    ) u_trig_qualifier (
        .clk    (clk),
        .rst_n  (rst_n),
        .trig   (trig),
        .arm    (state == IDLE),
        .track  (state == TRIG_HI),
        .rise   (rise),
        .accept (accept),
        .reject (reject)
    );

    // Echo width from the live distance; only sampled on the accept cycle, so
    // later distance changes cannot disturb an echo already scheduled.
    always_comb begin
        dist_ext = CNT_W'(distance_cm);
        below    = (dist_ext < MIN_D);
        above    = (dist_ext > MAX_D);
        dist_c   = dist_ext;
        if (below) begin
            dist_c = MIN_D;
        end else if (above) begin
            dist_c = MAX_D;
        end
        if (TIMEOUT_EN && (below || above)) begin
            width_nxt = TMO_W;
        end else begin
            width_nxt = dist_c * MULT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            echo_last <= '0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            trig_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= TRIG_HI;
                    end
                end
                TRIG_HI: begin
                    if (accept) begin
                        state     <= BURST;
                        echo_last <= width_nxt - CNT_W'(1);
                        busy      <= 1'b1;
                        cnt       <= '0;
                    end else if (reject) begin
                        state    <= IDLE;
                        trig_err <= 1'b1;
                    end
                end
                BURST: begin
                    if (cnt == BURST_LAST) begin
                        state <= ECHO;
                        echo  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ECHO: begin
                    if (cnt == echo_last) begin
                        state <= HOLDOFF;
                        echo  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_responder.sv
// Directed bench for hcsr04_responder with an echo/busy/trig_err pulse scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_hcsr04_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [8:0] distance_cm = 9'd0;
    logic       echo;
    logic       busy;
    logic       trig_err;

    int total = 0;
    int passes = 0;
    int cyc = 0;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t echo_q[$];
    pulse_t busy_q[$];
    pulse_t echo_exp[$];
    pulse_t busy_exp[$];
    int     err_q[$];
    int     err_exp[$];

    int     echo_t = 0;
    int     busy_t = 0;
    logic   echo_p = 1'b0;
    logic   busy_p = 1'b0;

`ifdef HCSR04_TIMEOUT_EN
    localparam int FAR_W = 38000;
`else
    localparam int FAR_W = 23200;
`endif

    always #5 clk = ~clk;

    hcsr04_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err)
    );

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: turns echo/busy/trig_err activity into records.
    always @(negedge clk) begin
        if (echo === 1'b1 && echo_p === 1'b0) echo_t = cyc;
        if (echo === 1'b0 && echo_p === 1'b1) echo_q.push_back(pulse_t'{echo_t, cyc - echo_t});
        if (busy === 1'b1 && busy_p === 1'b0) busy_t = cyc;
        if (busy === 1'b0 && busy_p === 1'b1) busy_q.push_back(pulse_t'{busy_t, cyc - busy_t});
        if (trig_err === 1'b1) err_q.push_back(cyc);
        echo_p = echo;
        busy_p = busy;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold trig high for hi sampled edges; e0 is the edge that samples it low.
    task automatic trigger(input int hi, output int e0);
        trig = 1'b1;
        repeat (hi) tick();
        trig = 1'b0;
        e0 = cyc + 1;
    endtask

    task automatic wait_busy_fall(input int limit);
        int n;
        n = 0;
        while (busy_q.size() == 0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic check_pulses(input string tag);
        pulse_t e;
        pulse_t o;
        int     ec;
        chk({tag, " echo count"}, echo_q.size(), echo_exp.size());
        while (echo_q.size() > 0 && echo_exp.size() > 0) begin
            e = echo_exp.pop_front();
            o = echo_q.pop_front();
            chk({tag, " echo rise"}, o.rise, e.rise);
            chk({tag, " echo width"}, o.width, e.width);
        end
        chk({tag, " busy count"}, busy_q.size(), busy_exp.size());
        while (busy_q.size() > 0 && busy_exp.size() > 0) begin
            e = busy_exp.pop_front();
            o = busy_q.pop_front();
            chk({tag, " busy rise"}, o.rise, e.rise);
            chk({tag, " busy width"}, o.width, e.width);
        end
        chk({tag, " trig_err count"}, err_q.size(), err_exp.size());
        while (err_q.size() > 0 && err_exp.size() > 0) begin
            ec = err_exp.pop_front();
            chk({tag, " trig_err cycle"}, err_q.pop_front(), ec);
        end
        echo_q.delete();
        busy_q.delete();
        err_q.delete();
        echo_exp.delete();
        busy_exp.delete();
        err_exp.delete();
    endtask

    initial begin
        int e0;
        int e1;

        // Reset state
        distance_cm = 9'd100;
        repeat (3) tick();
        chk("reset echo", echo, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset trig_err", trig_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // A: 10-cycle trigger at 100 cm; distance moves to 10 cm at E0+50
        trigger(10, e0);
        echo_exp.push_back(pulse_t'{e0 + 200, 5800});
        busy_exp.push_back(pulse_t'{e0, 16000});
        repeat (50) tick();
        distance_cm = 9'd10;
        wait_busy_fall(20000);
        check_pulses("A");

        // Short trigger is rejected with a single trig_err cycle
        distance_cm = 9'd100;
        trigger(9, e0);
        err_exp.push_back(e0);
        repeat (20) tick();
        chk("reject busy", busy, 1'b0);
        check_pulses("reject");

        // B: out-of-range distance, with a retrigger during ECHO that must be ignored
        distance_cm = 9'd450;
        trigger(10, e0);
        echo_exp.push_back(pulse_t'{e0 + 200, FAR_W});
        busy_exp.push_back(pulse_t'{e0, 200 + FAR_W + 10000});
        repeat (300) tick();
        chk("B echo high", echo, 1'b1);
        trigger(10, e1);
        tick();
        wait_busy_fall(60000);
        check_pulses("B");

        // C: trigger 5 cycles after busy drops, minimum distance
        repeat (5) tick();
        distance_cm = 9'd2;
        trigger(10, e0);
        echo_exp.push_back(pulse_t'{e0 + 200, 116});
        busy_exp.push_back(pulse_t'{e0, 10316});
        wait_busy_fall(20000);
        check_pulses("C");

        // D: reset mid-ECHO with trig held high across release
        trigger(10, e0);
        repeat (200) tick();
        chk("D echo before rise", echo, 1'b0);
        tick();
        chk("D echo at rise", echo, 1'b1);
        repeat (50) tick();
        trig = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("D echo after reset", echo, 1'b0);
        chk("D busy after reset", busy, 1'b0);
        rst_n = 1'b1;
        repeat (30) tick();
        chk("D busy held trig", busy, 1'b0);
        chk("D no trig_err", err_q.size(), 0);
        trig = 1'b0;
        repeat (2) tick();
        echo_q.delete();
        busy_q.delete();
        err_q.delete();
        trigger(10, e0);
        tick();
        chk("D retrigger busy", busy, 1'b1);
        chk("D retrigger E0", cyc, e0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
